ahb_error_slave_v2: RTL and testbench
=====================================

Name: ahb_error_slave_v2

Overview:
Parametrised successor to the team's default slave. It catches AHB transfers to unmapped address space and gives an AHB-compliant two-cycle ERROR response. An optional RAZ/WI OKAY mode is available, with a programmable number of wait states. It also keeps diagnostics (saturating error count, last offending address and direction) for the interconnect's status block. It sits behind the address decoder's default select line and feeds the slave response mux.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HRDATA width
WAIT_STATES, 0, wait cycles (HREADYOUT=0, HRESP=OKAY) before the response; legal range 0..15
RESP_MODE, 0, 0 = ERROR response; 1 = OKAY with read-as-zero/write-ignored
CNT_WIDTH, 16, width of the saturating error counter

Ports:
HCLK  in  1  bus clock
HRESET  in  1  synchronous reset, active-high
HSEL  in  1  default-slave select from the decoder
HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
HADDR  in  ADDR_WIDTH  address
HWRITE  in  1  direction
HREADY  in  1  bus-level HREADY (previous transfer complete)
HRDATA  out  DATA_WIDTH  read data, always zero
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
err_clr  in  1  synchronous clear of the diagnostics
err_count  out  CNT_WIDTH  number of error responses issued, saturating
last_err_addr  out  ADDR_WIDTH  HADDR of the most recent errored transfer
last_err_write  out  1  HWRITE of the most recent errored transfer
err_irq  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (HRESET=1 at a HCLK edge):
  - state=IDLE; HREADYOUT=1, HRESP=0, HRDATA=0.
  - err_count=0, last_err_addr=0, last_err_write=0, err_irq=0.
  - Reset mid-transfer abandons the response with no partial ERROR.
- Transfer accepted ("accept") when HSEL & HTRANS[1] & HREADY. IDLE/BUSY transfers get a zero-wait OKAY.
- FSM states: IDLE, WAIT, ERR1, ERR2. HREADYOUT/HRESP decode from the state flop only; no combinational path from inputs.
  - IDLE: HREADYOUT=1, HRESP=0.
    - On accept with WAIT_STATES>0: go to WAIT, load wcnt=WAIT_STATES-1.
    - On accept with WAIT_STATES=0: go to ERR1 (RESP_MODE=0) or stay in IDLE (RESP_MODE=1).
  - WAIT: HREADYOUT=0, HRESP=0.
    - wcnt decrements each cycle.
    - When wcnt==0: go to ERR1 (mode 0) or IDLE (mode 1).
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept is evaluated exactly as in IDLE (back-to-back transfer allowed); otherwise go to IDLE.
- Latency, mode 0: ERROR completes WAIT_STATES+2 cycles after the address phase.
- Latency, mode 1: OKAY completes WAIT_STATES+1 cycles after the address phase.
- Diagnostics update in mode 0 only, at the accept edge:
  - last_err_addr/last_err_write capture HADDR/HWRITE.
  - err_count increments and saturates at all-ones.
- err_clr:
  - Zeroes err_count, last_err_addr, last_err_write and err_irq.
  - Clear and accept in the same cycle: err_count=1 and the address is captured (the increment wins over the clear).
  - err_clr never affects the FSM.
- HWDATA is not a port; writes are ignored.
- HRDATA is constant 0 in all states.

Optional Feature:
- Macro AHB_ERRSLV_IRQ_EN.
- Defined: err_irq sets on every mode-0 accept and stays 1 until err_clr or reset. If set and clear happen together, set wins.
- Undefined: err_irq is tied 0 and no flop is inferred. The rest of the behaviour is identical.

Decomposition:
- ahb_params_pkg:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HRESP_OKAY/HRESP_ERROR constants.
  - errslv_state_t enum {ES_IDLE, ES_WAIT, ES_ERR1, ES_ERR2}.
- One sub-module, ahb_sat_counter (params WIDTH; ports inc, clr, count), used for err_count. It implements "clear then increment" semantics.

Test Plan:
- Reset with WAIT_STATES=0, RESP_MODE=0: NONSEQ read at 0xDEAD_0000 with HSEL=1 and HREADY=1.
  - Next cycle: HREADYOUT=0, HRESP=1.
  - Following cycle: HREADYOUT=1, HRESP=1.
  - Then: err_count=1, last_err_addr=0xDEAD_0000, last_err_write=0.
- WAIT_STATES=3: NONSEQ write → three cycles of HREADYOUT=0/HRESP=0, then ERR1, then ERR2. last_err_write=1.
- HTRANS=IDLE and BUSY with HSEL=1 → HREADYOUT stays 1, HRESP stays 0, err_count unchanged. A NONSEQ with HREADY=0 is not accepted.
- Back-to-back NONSEQ issued during ERR2 → second ERR1 follows immediately and err_count=2. err_clr asserted on that accept edge gives err_count=1.
- RESP_MODE=1, WAIT_STATES=2, read → two wait cycles, then OKAY with HRDATA=0. err_count stays 0.
- CNT_WIDTH=2 with 5 errors → err_count saturates at 3.
- AHB_ERRSLV_IRQ_EN defined: err_irq rises with the first error and clears on err_clr.
- Reset asserted during ERR1 → next cycle is IDLE, HREADYOUT=1, HRESP=0, err_count=0.

Source files
------------

// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings and the error-slave state type.
package ahb_params_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ES_IDLE = 2'd0,
      ES_WAIT = 2'd1,
      ES_ERR1 = 2'd2,
      ES_ERR2 = 2'd3
   } errslv_state_t;

endpackage

// File: rtl/ahb_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module ahb_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d, base;

   always_comb begin
      base    = clr ? '0 : count_q;
      count_d = base;
      if (inc && (base != '1))
         count_d = base + {{(WIDTH-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/ahb_error_slave_v2.sv
// AHB default slave: ERROR (or RAZ/WI OKAY) response with optional wait states
// and error diagnostics. Define AHB_ERRSLV_IRQ_EN to get a sticky err_irq flop.
module ahb_error_slave_v2
   import ahb_params_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 0,
   parameter int RESP_MODE   = 0,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [1:0]            HTRANS,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   input  logic                  err_clr,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0] last_err_addr,
   output logic                  last_err_write,
   output logic                  err_irq
);

   localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam bit HAS_WAIT = (WAIT_STATES > 0);
   localparam bit ERR_MODE = (RESP_MODE == 0);

   errslv_state_t   state_q, state_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic            accept, diag_upd;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic            write_q;

   // Only IDLE and ERR2 can take a new address phase.
   assign accept = HSEL && HREADY &&
                   ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                   ((state_q == ES_IDLE) || (state_q == ES_ERR2));
   assign diag_upd = accept && ERR_MODE;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         ES_IDLE, ES_ERR2: begin
            state_d = ES_IDLE;
            if (accept) begin
               if (HAS_WAIT) begin
                  state_d = ES_WAIT;
                  wcnt_d  = WCNT_INIT;
               end else if (ERR_MODE) begin
                  state_d = ES_ERR1;
               end
            end
         end
         ES_WAIT: begin
            if (wcnt_q == 4'd0) state_d = ERR_MODE ? ES_ERR1 : ES_IDLE;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         ES_ERR1: state_d = ES_ERR2;
         default: state_d = ES_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ES_IDLE;
         wcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign HREADYOUT = (state_q == ES_IDLE) || (state_q == ES_ERR2);
   assign HRESP     = ((state_q == ES_ERR1) || (state_q == ES_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign HRDATA    = '0;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         addr_q  <= '0;
         write_q <= 1'b0;
      end else if (diag_upd) begin
         addr_q  <= HADDR;
         write_q <= HWRITE;
      end else if (err_clr) begin
         addr_q  <= '0;
         write_q <= 1'b0;
      end
   end

   assign last_err_addr  = addr_q;
   assign last_err_write = write_q;

   ahb_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
      .clk   (HCLK),
      .rst   (HRESET),
      .inc   (diag_upd),
      .clr   (err_clr),
      .count (err_count)
   );

`ifdef AHB_ERRSLV_IRQ_EN
   logic irq_q;
   always_ff @(posedge HCLK) begin
      if (HRESET)        irq_q <= 1'b0;
      else if (diag_upd) irq_q <= 1'b1;
      else if (err_clr)  irq_q <= 1'b0;
   end
   assign err_irq = irq_q;
`else
   assign err_irq = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_error_slave_v2.sv
// Directed bench for ahb_error_slave_v2 across four parameter sets sharing one stimulus bus.
module tb_ahb_error_slave_v2;
   import ahb_params_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        HSEL = 1'b0;
   logic [1:0]  HTRANS = HTRANS_IDLE;
   logic [31:0] HADDR = '0;
   logic        HWRITE = 1'b0;
   logic        HREADY = 1'b1;
   logic        err_clr = 1'b0;

   // a: WS=0 ERROR; w: WS=3 ERROR; o: WS=2 OKAY; s: CNT_WIDTH=2
   logic [31:0] rd_a, rd_w, rd_o, rd_s;
   logic        ro_a, ro_w, ro_o, ro_s;
   logic        rs_a, rs_w, rs_o, rs_s;
   logic [15:0] cnt_a, cnt_w, cnt_o;
   logic [1:0]  cnt_s;
   logic [31:0] la_a, la_w, la_o, la_s;
   logic        lw_a, lw_w, lw_o, lw_s;
   logic        irq_a, irq_w, irq_o, irq_s;

   int checks = 0;
   int errors = 0;

   always #5 HCLK = ~HCLK;

   ahb_error_slave_v2 #(.WAIT_STATES(0), .RESP_MODE(0), .CNT_WIDTH(16)) dut_a (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
      .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(rd_a), .HREADYOUT(ro_a), .HRESP(rs_a),
      .err_clr(err_clr), .err_count(cnt_a), .last_err_addr(la_a),
      .last_err_write(lw_a), .err_irq(irq_a));

   ahb_error_slave_v2 #(.WAIT_STATES(3), .RESP_MODE(0), .CNT_WIDTH(16)) dut_w (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
      .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(rd_w), .HREADYOUT(ro_w), .HRESP(rs_w),
      .err_clr(err_clr), .err_count(cnt_w), .last_err_addr(la_w),
      .last_err_write(lw_w), .err_irq(irq_w));

   ahb_error_slave_v2 #(.WAIT_STATES(2), .RESP_MODE(1), .CNT_WIDTH(16)) dut_o (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
      .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(rd_o), .HREADYOUT(ro_o), .HRESP(rs_o),
      .err_clr(err_clr), .err_count(cnt_o), .last_err_addr(la_o),
      .last_err_write(lw_o), .err_irq(irq_o));

   ahb_error_slave_v2 #(.WAIT_STATES(0), .RESP_MODE(0), .CNT_WIDTH(2)) dut_s (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
      .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(rd_s), .HREADYOUT(ro_s), .HRESP(rs_s),
      .err_clr(err_clr), .err_count(cnt_s), .last_err_addr(la_s),
      .last_err_write(lw_s), .err_irq(irq_s));

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic bus_idle();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HREADY = 1'b1; HWRITE = 1'b0; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      bus_idle();
      HRESET = 1'b1;
      tick(); tick();
      HRESET = 1'b0;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic w);
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = w; HREADY = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ro_a !== 1'b1)  begin errors++; $display("FAIL reset_hreadyout got %b want 1", ro_a); end
      checks++; if (rs_a !== 1'b0)  begin errors++; $display("FAIL reset_hresp got %b want 0", rs_a); end
      checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h want 0", rd_a); end
      checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt_a); end
      checks++; if (la_a !== 32'h0 || lw_a !== 1'b0) begin errors++; $display("FAIL reset_last got %h/%b want 0/0", la_a, lw_a); end
      checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_a); end
   endtask

   task automatic test_error_read();
      do_reset();
      addr_phase(32'hDEAD_0000, 1'b0);
      tick(); bus_idle();
      checks++; if ({ro_a, rs_a} !== 2'b01) begin errors++; $display("FAIL err1 got rdy/resp=%b want 01", {ro_a, rs_a}); end
      tick();
      checks++; if ({ro_a, rs_a} !== 2'b11) begin errors++; $display("FAIL err2 got rdy/resp=%b want 11", {ro_a, rs_a}); end
      tick();
      checks++; if ({ro_a, rs_a} !== 2'b10) begin errors++; $display("FAIL err_back_idle got rdy/resp=%b want 10", {ro_a, rs_a}); end
      checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL err_count1 got %0d want 1", cnt_a); end
      checks++; if (la_a !== 32'hDEAD_0000) begin errors++; $display("FAIL last_addr got %h want dead0000", la_a); end
      checks++; if (lw_a !== 1'b0) begin errors++; $display("FAIL last_write got %b want 0", lw_a); end
   endtask

   task automatic test_wait_states();
      do_reset();
      addr_phase(32'h1234_5678, 1'b1);
      tick(); bus_idle();
      for (int i = 0; i < 3; i++) begin
         checks++; if ({ro_w, rs_w} !== 2'b00) begin errors++; $display("FAIL wait%0d got rdy/resp=%b want 00", i, {ro_w, rs_w}); end
         tick();
      end
      checks++; if ({ro_w, rs_w} !== 2'b01) begin errors++; $display("FAIL wait_err1 got rdy/resp=%b want 01", {ro_w, rs_w}); end
      tick();
      checks++; if ({ro_w, rs_w} !== 2'b11) begin errors++; $display("FAIL wait_err2 got rdy/resp=%b want 11", {ro_w, rs_w}); end
      checks++; if (lw_w !== 1'b1 || la_w !== 32'h1234_5678) begin errors++; $display("FAIL wait_last got %h/%b want 12345678/1", la_w, lw_w); end
      checks++; if (cnt_w !== 16'd1) begin errors++; $display("FAIL wait_count got %0d want 1", cnt_w); end
   endtask

   task automatic test_no_accept();
      do_reset();
      HSEL = 1'b1; HTRANS = HTRANS_IDLE;
      tick();
      checks++; if ({ro_a, rs_a} !== 2'b10) begin errors++; $display("FAIL idle_trans got rdy/resp=%b want 10", {ro_a, rs_a}); end
      HTRANS = HTRANS_BUSY;
      tick();
      checks++; if ({ro_a, rs_a} !== 2'b10) begin errors++; $display("FAIL busy_trans got rdy/resp=%b want 10", {ro_a, rs_a}); end
      addr_phase(32'h0000_0040, 1'b0); HREADY = 1'b0;
      tick(); bus_idle();
      checks++; if ({ro_a, rs_a} !== 2'b10) begin errors++; $display("FAIL hready_low got rdy/resp=%b want 10", {ro_a, rs_a}); end
      checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL no_accept_count got %0d want 0", cnt_a); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      addr_phase(32'hA000_0000, 1'b0);
      tick(); bus_idle();
      tick();
      addr_phase(32'hA000_0004, 1'b1);
      tick(); bus_idle();
      checks++; if ({ro_a, rs_a} !== 2'b01) begin errors++; $display("FAIL b2b_err1 got rdy/resp=%b want 01", {ro_a, rs_a}); end
      checks++; if (cnt_a !== 16'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", cnt_a); end
      checks++; if (la_a !== 32'hA000_0004 || lw_a !== 1'b1) begin errors++; $display("FAIL b2b_last got %h/%b want a0000004/1", la_a, lw_a); end
      tick();
      addr_phase(32'hA000_0008, 1'b0); err_clr = 1'b1;
      tick(); bus_idle();
      checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL clr_inc_count got %0d want 1", cnt_a); end
      checks++; if (la_a !== 32'hA000_0008) begin errors++; $display("FAIL clr_inc_addr got %h want a0000008", la_a); end
      tick(); tick();
      err_clr = 1'b1;
      tick(); err_clr = 1'b0;
      checks++; if (cnt_a !== 16'd0 || la_a !== 32'h0) begin errors++; $display("FAIL clr_only got %0d/%h want 0/0", cnt_a, la_a); end
      checks++; if ({ro_a, rs_a} !== 2'b10) begin errors++; $display("FAIL clr_fsm got rdy/resp=%b want 10", {ro_a, rs_a}); end
   endtask

   task automatic test_okay_mode();
      do_reset();
      addr_phase(32'h5555_0000, 1'b0);
      tick(); bus_idle();
      checks++; if ({ro_o, rs_o} !== 2'b00) begin errors++; $display("FAIL okay_wait0 got rdy/resp=%b want 00", {ro_o, rs_o}); end
      tick();
      checks++; if ({ro_o, rs_o} !== 2'b00) begin errors++; $display("FAIL okay_wait1 got rdy/resp=%b want 00", {ro_o, rs_o}); end
      tick();
      checks++; if ({ro_o, rs_o} !== 2'b10) begin errors++; $display("FAIL okay_done got rdy/resp=%b want 10", {ro_o, rs_o}); end
      checks++; if (rd_o !== 32'h0) begin errors++; $display("FAIL okay_hrdata got %h want 0", rd_o); end
      checks++; if (cnt_o !== 16'd0 || la_o !== 32'h0) begin errors++; $display("FAIL okay_diag got %0d/%h want 0/0", cnt_o, la_o); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         addr_phase(32'h0000_1000 + 32'(i), 1'b0);
         tick(); bus_idle();
         tick(); tick();
         if (i == 1) begin
            checks++; if (cnt_s !== 2'd2) begin errors++; $display("FAIL sat_mid got %0d want 2", cnt_s); end
         end
      end
      checks++; if (cnt_s !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", cnt_s); end
      checks++; if (la_s !== 32'h0000_1004) begin errors++; $display("FAIL sat_last got %h want 00001004", la_s); end
   endtask

   task automatic test_irq();
      logic exp_irq;
`ifdef AHB_ERRSLV_IRQ_EN
      exp_irq = 1'b1;
`else
      exp_irq = 1'b0;
`endif
      do_reset();
      addr_phase(32'hBEEF_0000, 1'b1);
      tick(); bus_idle();
      checks++; if (irq_a !== exp_irq) begin errors++; $display("FAIL irq_set got %b want %b", irq_a, exp_irq); end
      tick(); tick(); tick();
      checks++; if (irq_a !== exp_irq) begin errors++; $display("FAIL irq_sticky got %b want %b", irq_a, exp_irq); end
      checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_okay_mode got %b want 0", irq_o); end
      err_clr = 1'b1;
      tick(); err_clr = 1'b0;
      checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_clr got %b want 0", irq_a); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      addr_phase(32'hC000_0000, 1'b0);
      tick(); bus_idle();
      checks++; if ({ro_a, rs_a} !== 2'b01) begin errors++; $display("FAIL rmid_err1 got rdy/resp=%b want 01", {ro_a, rs_a}); end
      HRESET = 1'b1;
      tick();
      checks++; if ({ro_a, rs_a} !== 2'b10) begin errors++; $display("FAIL rmid_idle got rdy/resp=%b want 10", {ro_a, rs_a}); end
      checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", cnt_a); end
      HRESET = 1'b0;
      tick();
      checks++; if ({ro_a, rs_a} !== 2'b10) begin errors++; $display("FAIL rmid_after got rdy/resp=%b want 10", {ro_a, rs_a}); end
   endtask

   initial begin
      test_reset();
      test_error_read();
      test_wait_states();
      test_no_accept();
      test_back_to_back();
      test_okay_mode();
      test_saturation();
      test_irq();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
